// File: rtl/acl_sys_description_rom_reader.sv
// Host read adapter for the 64-bit system-description ROM: serves 32-bit reads
// from a one-line cache of the last fetched ROM word, fetching on a miss.
module acl_sys_description_rom_reader #(
    parameter int ROM_LATENCY = 2,
    parameter int ROM_AW      = 9
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ROM_AW:0]   s_address,
    input  logic              s_read,
    input  logic              s_write,
    input  logic [31:0]       s_writedata,
    output logic              s_waitrequest,
    output logic [31:0]       s_readdata,
    output logic              s_readdatavalid,
    input  logic              flush,
    output logic [ROM_AW-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_clken,
    input  logic [63:0]       m_readdata
);

    localparam int CNT_W = $clog2(ROM_LATENCY + 1) + 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [63:0]         line_r, line_s;
    logic [ROM_AW-1:0]   tag_r, tag_s;
    logic                line_valid_r, line_valid_s;
    logic                half_r, half_s;
    logic [31:0]         rdata_r, rdata_s;
    logic                rvalid_r, rvalid_s;
    logic [ROM_AW-1:0]   maddr_r, maddr_s;
    logic                hit_s;
    logic                write_unused_s;

    function automatic logic [31:0] sel_half(input logic [63:0] word, input logic hi);
        return hi ? word[63:32] : word[31:0];
    endfunction

    // Writes are never stored; the ROM is read-only from the host side.
    assign write_unused_s = ^{s_write, s_writedata};

    assign hit_s = line_valid_r && (tag_r == s_address[ROM_AW:1]) && !flush;

    // Next-state and datapath decode for the IDLE/FETCH controller.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        line_s       = line_r;
        tag_s        = tag_r;
        line_valid_s = line_valid_r;
        half_s       = half_r;
        rdata_s      = rdata_r;
        rvalid_s     = 1'b0;
        maddr_s      = maddr_r;
        case (state_r)
            ST_IDLE: begin
                if (flush) begin
                    line_valid_s = 1'b0;
                end else begin
                    line_valid_s = line_valid_r;
                end
                if (s_read) begin
                    if (hit_s) begin
                        rdata_s  = sel_half(line_r, s_address[0]);
                        rvalid_s = 1'b1;
                    end else begin
                        maddr_s = s_address[ROM_AW:1];
                        half_s  = s_address[0];
                        cnt_s   = {CNT_W{1'b0}};
                        state_s = ST_FETCH;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                // A flush on the capture edge still answers the read but leaves the line invalid.
                if (cnt_r == CNT_W'(ROM_LATENCY)) begin
                    line_s       = m_readdata;
                    tag_s        = maddr_r;
                    line_valid_s = ~flush;
                    rdata_s      = sel_half(m_readdata, half_r);
                    rvalid_s     = 1'b1;
                    state_s      = ST_IDLE;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            line_r       <= 64'h0;
            tag_r        <= {ROM_AW{1'b0}};
            line_valid_r <= 1'b0;
            half_r       <= 1'b0;
            rdata_r      <= 32'h0;
            rvalid_r     <= 1'b0;
            maddr_r      <= {ROM_AW{1'b0}};
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            line_r       <= line_s;
            tag_r        <= tag_s;
            line_valid_r <= line_valid_s;
            half_r       <= half_s;
            rdata_r      <= rdata_s;
            rvalid_r     <= rvalid_s;
            maddr_r      <= maddr_s;
        end
    end

    assign s_waitrequest   = (state_r == ST_FETCH);
    assign m_chipselect    = (state_r == ST_FETCH);
    assign m_clken         = (state_r == ST_FETCH);
    assign s_readdata      = rdata_r;
    assign s_readdatavalid = rvalid_r;
    assign m_address       = maddr_r;

endmodule

// File: tb/tb_acl_sys_description_rom_reader.sv
// Self-checking bench for acl_sys_description_rom_reader: directed cases plus
// randomized reads/writes/flushes checked against a transaction-level cache model.
module tb_acl_sys_description_rom_reader;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          resetn;
    logic [AW:0]   s_address;
    logic          s_read;
    logic          s_write;
    logic [31:0]   s_writedata;
    logic          s_waitrequest;
    logic [31:0]   s_readdata;
    logic          s_readdatavalid;
    logic          flush;
    logic [AW-1:0] m_address;
    logic          m_chipselect;
    logic          m_clken;
    logic [63:0]   m_readdata;

    always #5 clk = ~clk;

    acl_sys_description_rom_reader #(.ROM_LATENCY(2), .ROM_AW(AW)) dut (
        .clk(clk), .resetn(resetn),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .flush(flush), .m_address(m_address), .m_chipselect(m_chipselect),
        .m_clken(m_clken), .m_readdata(m_readdata)
    );

    // ROM model: address register then output register, both gated by clken.
    logic [63:0]   mem [0:511];
    logic [AW-1:0] rom_addr_q;
    logic [63:0]   rom_q;
    always @(posedge clk) begin
        if (m_clken && m_chipselect) begin
            rom_addr_q <= m_address;
            rom_q      <= mem[rom_addr_q];
        end
    end
    assign m_readdata = rom_q;

    int n_cmp = 0;
    int n_err = 0;

    // Reference cache model: which ROM word (if any) is held.
    bit          mvalid = 1'b0;
    logic [AW-1:0] mtag = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_half(input logic [AW:0] a);
        logic [63:0] w;
        w = mem[a[AW:1]];
        return a[0] ? w[63:32] : w[31:0];
    endfunction

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_rdata"},  s_readdata, 64'h0);
        check_eq({tag, "_rvalid"}, s_readdatavalid, 64'h0);
        check_eq({tag, "_maddr"},  m_address, 64'h0);
        check_eq({tag, "_wait"},   s_waitrequest, 64'h0);
        check_eq({tag, "_cs"},     m_chipselect, 64'h0);
        check_eq({tag, "_clken"},  m_clken, 64'h0);
    endtask

    // One read (optionally with flush / simultaneous write / flush on capture edge).
    task automatic rd(input logic [AW:0] a, input bit fl, input bit wr, input bit fcap);
        bit            miss;
        int            lat, wt_cnt, cs_cnt;
        logic [AW-1:0] maddr;
        miss = !(mvalid && (mtag == a[AW:1]) && !fl);
        @(negedge clk);
        s_address = a; s_read = 1'b1; s_write = wr; s_writedata = 32'hDEADBEEF; flush = fl;
        @(posedge clk);
        #1 s_read = 1'b0; s_write = 1'b0; flush = 1'b0;
        lat = 0; wt_cnt = 0; cs_cnt = 0;
        @(negedge clk);
        maddr = m_address;
        while (!s_readdatavalid && lat < 10) begin
            if (s_waitrequest) wt_cnt++;
            if (m_chipselect)  cs_cnt++;
            @(negedge clk);
            lat++;
            if (fcap && lat == 2) flush = 1'b1;
        end
        flush = 1'b0;
        check_eq("rd_latency", lat, miss ? 3 : 0);
        check_eq("rd_data", s_readdata, ref_half(a));
        check_eq("rd_wait_cycles", wt_cnt, miss ? 3 : 0);
        check_eq("rd_rom_cycles", cs_cnt, miss ? 3 : 0);
        check_eq("rd_wait_low_on_valid", s_waitrequest, 1'b0);
        if (miss) check_eq("rd_m_address", maddr, a[AW:1]);
        @(negedge clk);
        check_eq("rd_valid_one_cycle", s_readdatavalid, 1'b0);
        if (fl) mvalid = 1'b0;
        if (miss) begin
            mvalid = !fcap;
            mtag   = a[AW:1];
        end
    endtask

    // Two reads on consecutive cycles, both expected to hit.
    task automatic b2b(input logic [AW:0] a0, input logic [AW:0] a1);
        @(negedge clk);
        s_address = a0; s_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("b2b_valid0", s_readdatavalid, 1'b1);
        check_eq("b2b_data0", s_readdata, ref_half(a0));
        check_eq("b2b_wait0", s_waitrequest, 1'b0);
        check_eq("b2b_cs0", m_chipselect, 1'b0);
        s_address = a1;
        @(posedge clk);
        #1 s_read = 1'b0;
        @(negedge clk);
        check_eq("b2b_valid1", s_readdatavalid, 1'b1);
        check_eq("b2b_data1", s_readdata, ref_half(a1));
        check_eq("b2b_cs1", m_chipselect, 1'b0);
        @(negedge clk);
        check_eq("b2b_valid_end", s_readdatavalid, 1'b0);
    endtask

    task automatic wr_only(input logic [AW:0] a, input logic [31:0] d);
        bit cs, rv;
        @(negedge clk);
        s_address = a; s_write = 1'b1; s_writedata = d;
        @(posedge clk);
        #1 s_write = 1'b0;
        cs = 1'b0; rv = 1'b0;
        repeat (4) begin
            @(negedge clk);
            cs |= m_chipselect;
            rv |= s_readdatavalid;
        end
        check_eq("wr_no_cs", cs, 1'b0);
        check_eq("wr_no_valid", rv, 1'b0);
    endtask

    initial begin
        bit rv;
        for (int i = 0; i < 512; i++) mem[i] = {$urandom, $urandom};
        mem[0] = 64'h11223344_55667788;
        resetn = 1'b0; s_address = '0; s_read = 1'b0; s_write = 1'b0;
        s_writedata = 32'h0; flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        resetn = 1'b1;

        rd(10'h000, 1'b0, 1'b0, 1'b0);
        rd(10'h001, 1'b0, 1'b0, 1'b0);
        rd(10'h1FF, 1'b0, 1'b0, 1'b0);
        b2b(10'h1FE, 10'h1FF);

        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        mvalid = 1'b0;
        rd(10'h001, 1'b0, 1'b0, 1'b0);
        wr_only(10'h001, 32'hDEADBEEF);
        rd(10'h001, 1'b0, 1'b0, 1'b0);

        rd(10'h020, 1'b0, 1'b1, 1'b0);
        rd(10'h040, 1'b0, 1'b0, 1'b1);
        rd(10'h041, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a fetch.
        @(negedge clk);
        s_address = 10'h060; s_read = 1'b1; s_write = 1'b1;
        @(posedge clk);
        #1 s_read = 1'b0; s_write = 1'b0;
        @(negedge clk);
        check_eq("rst_fetch_wait", s_waitrequest, 1'b1);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle_zero("rst_mid");
        resetn = 1'b1;
        mvalid = 1'b0;
        rv = 1'b0;
        repeat (5) begin
            @(negedge clk);
            rv |= s_readdatavalid;
        end
        check_eq("rst_no_valid", rv, 1'b0);
        rd(10'h060, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            logic [AW:0] a;
            int r;
            a = {$urandom_range(0, 3) == 3 ? 9'h1FF : 9'($urandom_range(0, 2) * 5), 1'($urandom)};
            r = $urandom_range(0, 9);
            if (r == 0) wr_only(a, $urandom);
            else        rd(a, r == 1, r == 2, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/acl_sys_description_rom_reader.md
# acl_sys_description_rom_reader

Host-side read adapter placed directly upstream of the 64-bit kernel-interface system-description ROM. It accepts 32-bit Avalon-MM reads from the host control bridge, fetches the containing 64-bit ROM word over a fixed-latency port, and returns the selected 32-bit half. A one-line cache (last fetched 64-bit word) serves the sequential low/high-half read pair in one cycle. Writes are accepted and discarded, so the ROM contents are never host-writable.

## Interface
- ROM_LATENCY, 2: cycles from ROM address/clken sampled to `m_readdata` valid (address register plus output register).
- ROM_AW, 9: ROM word address width; host word address width is ROM_AW+1.
- clk  in  1  sole clock.
- resetn  in  1  reset, synchronous, active-low.
- s_address  in  ROM_AW+1  32-bit word address; bit 0 selects the half (0 = [31:0], 1 = [63:32]).
- s_read  in  1  read request.
- s_write  in  1  write request (discarded).
- s_writedata  in  32  ignored.
- s_waitrequest  out  1  high while a fetch is in progress.
- s_readdata  out  32  registered read data.
- s_readdatavalid  out  1  one-cycle pulse per accepted read.
- flush  in  1  invalidates the cache line.
- m_address  out  ROM_AW  ROM word address (registered).
- m_chipselect  out  1  high during FETCH.
- m_clken  out  1  high during FETCH.
- m_readdata  in  64  ROM data.

## Operation
- State machine: IDLE and FETCH. `s_waitrequest` = (state == FETCH).
- A command is accepted on a clk edge where state is IDLE and `s_read` or `s_write` is high. If both are high, the read wins and the write is dropped.
- Accepted write: no state change and no `s_readdatavalid`.
- Accepted read, hit: a hit requires line_valid, tag == `s_address[ROM_AW:1]`, and `flush` low.
  - `s_readdata` <= the selected half of the line.
  - `s_readdatavalid` <= 1 on the next cycle.
  - State stays IDLE, so back-to-back hits are sustained at one per cycle.
- Accepted read, miss:
  - `m_address` <= `s_address[ROM_AW:1]`.
  - The half-select bit is latched.
  - Counter <= 0, then go to FETCH.
- FETCH:
  - `m_chipselect` = `m_clken` = 1 and the counter increments each cycle.
  - On the edge where counter == ROM_LATENCY: line <= `m_readdata`, tag <= `m_address`, line_valid <= ~`flush`, `s_readdata` <= the latched half, `s_readdatavalid` <= 1, and the state goes to IDLE.
- `flush` high in IDLE clears line_valid on that edge, and a read accepted on the same edge is treated as a miss.
- `flush` during FETCH does not abort the fetch. The response is still delivered, but the line is left invalid if `flush` is high on the capture edge.
- Only one read is outstanding; no new command is accepted in FETCH.
- Reset (`resetn` low at a clk edge), including mid-FETCH:
  - State goes to IDLE, line_valid = 0, counter = 0, and no response is issued for the aborted read.
  - `s_readdata` = 0, `s_readdatavalid` = 0, `m_address` = 0.
  - `s_waitrequest` = `m_chipselect` = `m_clken` = 0 (combinational, follows IDLE).

## Timing
- Hit latency: `s_readdatavalid` is high in the cycle after the accept edge E0.
- Miss latency: the ROM samples the address at E1 and `m_readdata` is valid after E(ROM_LATENCY). Capture is at E(ROM_LATENCY+1), and `s_readdatavalid` is high in the following cycle: 3 cycles after E0 for ROM_LATENCY = 2.
- `s_waitrequest` is high for the ROM_LATENCY+1 cycles after a miss is accepted, then low in the cycle `s_readdatavalid` is high.
- `s_readdatavalid` is never high for two cycles on one read. It can be high on consecutive cycles only for separate accepted hits.
- All outputs are registered except `s_waitrequest`, `m_chipselect` and `m_clken`, which decode the state register.

## Test plan
- Reset then miss:
  - Stimulus: ROM word 0x000 = 0x11223344_55667788, read `s_address` 0x000.
  - Response: `m_address` = 0x000, `s_waitrequest` high for 3 cycles, `s_readdata` = 0x55667788 with valid 3 cycles after accept.
- Sequential hit:
  - Stimulus: read 0x001 immediately after the previous read.
  - Response: `s_readdata` = 0x11223344, valid 1 cycle after accept, no ROM access (`m_chipselect` stays low).
- Different line, then back-to-back hits:
  - Stimulus: read 0x1FF (ROM word 0x0FF), then 0x1FE and 0x1FF on consecutive cycles.
  - Response: one miss, then two consecutive 1-cycle hits returning the low and high halves.
- Flush and writes:
  - Stimulus: pulse `flush`, re-read 0x001, then `s_write` to 0x001 with 0xDEADBEEF, then read 0x001.
  - Response: the first read misses (3-cycle latency). The write produces no `s_readdatavalid` and no `m_chipselect`. The final read returns the unchanged 0x11223344 as a hit.
- Simultaneous and reset:
  - Stimulus: `s_read` and `s_write` high together on a miss address, then `resetn` low during FETCH, then the same read again.
  - Response: the read is serviced and the write dropped. No `s_readdatavalid` follows the reset and all outputs are 0. The re-read is a miss.
